// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl: sequencer in front of the 3x3 Sobel core.
// Builds the nine window taps from two line buffers and aligns framing flags with the core latency.
module sobel_window_ctrl #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIX_W      = 24,
    parameter int CORE_LAT   = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    input  logic             IN_SOF,
    input  logic             IN_EOL,
    input  logic [PIX_W-1:0] IN_DATA,
    output logic [PIX_W-1:0] D00,
    output logic [PIX_W-1:0] D01,
    output logic [PIX_W-1:0] D02,
    output logic [PIX_W-1:0] D10,
    output logic [PIX_W-1:0] D11,
    output logic [PIX_W-1:0] D12,
    output logic [PIX_W-1:0] D20,
    output logic [PIX_W-1:0] D21,
    output logic [PIX_W-1:0] D22,
    output logic             WIN_VALID,
    output logic             OUT_VALID,
    output logic             OUT_SOF,
    output logic             OUT_EOL,
    output logic             OUT_BORDER,
    output logic             FRAME_DONE,
    output logic             ERR_LINE,
    output logic             FRAME_ABORT
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESYNC = 2'd2
    } state_t;

    typedef struct packed {
        logic valid;
        logic sof;
        logic eol;
        logic border;
    } beat_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    col, pos_col;
    logic [RW-1:0]    row, pos_row;
    logic             accept, line_err, frame_end, abort_hit;
    logic [PIX_W-1:0] lb0 [IMG_WIDTH];
    logic [PIX_W-1:0] lb1 [IMG_WIDTH];
    logic [PIX_W-1:0] lb0_rd, lb1_rd;
    beat_t            win_beat;
    beat_t            pipe [CORE_LAT];

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        pos_col   = col;
        pos_row   = row;
        line_err  = 1'b0;
        frame_end = 1'b0;
        abort_hit = 1'b0;
        if (IN_VALID) begin
            case (state)
                IDLE, RESYNC: accept = IN_SOF;
                ACTIVE:       accept = 1'b1;
                default:      accept = 1'b0;
            endcase
        end
        if (accept) begin
            // SOF is resolved before the EOL check, so SOF+EOL checks EOL at col 0
            if (IN_SOF) begin
                pos_col   = '0;
                pos_row   = '0;
                abort_hit = (state == ACTIVE) && ((col != '0) || (row != '0));
            end
            line_err  = IN_EOL ? (pos_col != COL_LAST) : (pos_col == COL_LAST);
            frame_end = IN_EOL && (pos_col == COL_LAST) && (pos_row == ROW_LAST);
            if (line_err)
                state_nxt = RESYNC;
            else if (frame_end)
                state_nxt = IDLE;
            else
                state_nxt = ACTIVE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (line_err || frame_end) begin
                col <= '0;
                row <= '0;
            end else if (IN_EOL) begin
                col <= '0;
                row <= pos_row + RW'(1);
            end else begin
                col <= pos_col + CW'(1);
                row <= pos_row;
            end
        end
    end

    assign lb0_rd = lb0[pos_col];
    assign lb1_rd = lb1[pos_col];

    // NOTE: line-buffer RAMs are deliberately left unreset; the row masks below hide stale contents.
    always_ff @(posedge CLK) begin
        if (!RESET && accept) begin
            lb0[pos_col] <= lb1_rd;
            lb1[pos_col] <= IN_DATA;
        end
    end

    // Newest column loads from the stream and buffers; older columns shift, zeroed left of the frame
    always_ff @(posedge CLK) begin
        if (RESET) begin
            {D00, D01, D02, D10, D11, D12, D20, D21, D22} <= '0;
        end else if (accept) begin
            D20 <= IN_DATA;
            D10 <= (pos_row >= RW'(1)) ? lb1_rd : '0;
            D00 <= (pos_row >= RW'(2)) ? lb0_rd : '0;
            D21 <= (pos_col == '0) ? '0 : D20;
            D11 <= (pos_col == '0) ? '0 : D10;
            D01 <= (pos_col == '0) ? '0 : D00;
            D22 <= (pos_col < CW'(2)) ? '0 : D21;
            D12 <= (pos_col < CW'(2)) ? '0 : D11;
            D02 <= (pos_col < CW'(2)) ? '0 : D01;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            win_beat    <= '0;
            FRAME_DONE  <= 1'b0;
            ERR_LINE    <= 1'b0;
            FRAME_ABORT <= 1'b0;
        end else begin
            win_beat.valid  <= accept && !line_err;
            win_beat.sof    <= accept && !line_err && (pos_row == '0) && (pos_col == '0);
            win_beat.eol    <= accept && !line_err && (pos_col == COL_LAST);
            win_beat.border <= accept && !line_err && ((pos_row < RW'(2)) || (pos_col < CW'(2)));
            FRAME_DONE      <= frame_end && !line_err;
            ERR_LINE        <= line_err;
            FRAME_ABORT     <= abort_hit;
        end
    end

    // Delay line keeps draining beats already in flight even after a frame error
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < CORE_LAT; i++)
                pipe[i] <= '0;
        end else begin
            pipe[0] <= win_beat;
            for (int i = 1; i < CORE_LAT; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    assign WIN_VALID  = win_beat.valid;
    assign OUT_VALID  = pipe[CORE_LAT-1].valid;
    assign OUT_SOF    = pipe[CORE_LAT-1].sof;
    assign OUT_EOL    = pipe[CORE_LAT-1].eol;
    assign OUT_BORDER = pipe[CORE_LAT-1].border;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl: pixels carry {row, col, 8'h00}, so every tap has a known
// expected value; OUT_* beats are scored against a queue filled as pixels are sent.
module tb_sobel_window_ctrl;

    localparam int W   = 8;
    localparam int H   = 6;
    localparam int LAT = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        IN_VALID, IN_SOF, IN_EOL;
    logic [23:0] IN_DATA;
    logic [23:0] D00, D01, D02, D10, D11, D12, D20, D21, D22;
    logic        WIN_VALID, OUT_VALID, OUT_SOF, OUT_EOL, OUT_BORDER;
    logic        FRAME_DONE, ERR_LINE, FRAME_ABORT;

    sobel_window_ctrl #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .PIX_W     (24),
        .CORE_LAT  (LAT)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .IN_VALID   (IN_VALID),
        .IN_SOF     (IN_SOF),
        .IN_EOL     (IN_EOL),
        .IN_DATA    (IN_DATA),
        .D00        (D00),
        .D01        (D01),
        .D02        (D02),
        .D10        (D10),
        .D11        (D11),
        .D12        (D12),
        .D20        (D20),
        .D21        (D21),
        .D22        (D22),
        .WIN_VALID  (WIN_VALID),
        .OUT_VALID  (OUT_VALID),
        .OUT_SOF    (OUT_SOF),
        .OUT_EOL    (OUT_EOL),
        .OUT_BORDER (OUT_BORDER),
        .FRAME_DONE (FRAME_DONE),
        .ERR_LINE   (ERR_LINE),
        .FRAME_ABORT(FRAME_ABORT)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_r = -10;
    int          last_c = -10;
    int          n_win, n_out, n_border, n_done, n_err, n_abort;
    int          first_win, first_out, drive_cyc, exp_border;
    logic [2:0]  sb [$];
    logic [215:0] taps_now;

    assign taps_now = {D00, D01, D02, D10, D11, D12, D20, D21, D22};

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] pv(input int r, input int c);
        if (r < 0 || c < 0) return '0;
        return {8'(r), 8'(c), 8'h00};
    endfunction

    function automatic logic [215:0] exp_taps(input int r, input int c);
        return {pv(r-2, c), pv(r-2, c-1), pv(r-2, c-2),
                pv(r-1, c), pv(r-1, c-1), pv(r-1, c-2),
                pv(r,   c), pv(r,   c-1), pv(r,   c-2)};
    endfunction

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (WIN_VALID) begin
            n_win++;
            if (first_win < 0) first_win = cyc;
        end
        if (FRAME_DONE)  n_done++;
        if (ERR_LINE)    n_err++;
        if (FRAME_ABORT) n_abort++;
        if (OUT_VALID) begin
            n_out++;
            if (OUT_BORDER) n_border++;
            if (first_out < 0) first_out = cyc;
            if (sb.size() == 0)
                check("out_valid_unexpected", OUT_VALID, 1'b0);
            else
                check("out_flags", {OUT_SOF, OUT_EOL, OUT_BORDER}, sb.pop_front());
        end
    end

    // Drive one pixel at a negedge, then sample the registered result at the next negedge.
    task automatic pixel(input int r, input int c, input bit sof, input bit eol,
                         input bit acc, input bit win);
        IN_VALID = 1'b1;
        IN_SOF   = sof;
        IN_EOL   = eol;
        IN_DATA  = pv(r, c);
        if (win) sb.push_back({(r == 0 && c == 0), (c == W-1), (r < 2 || c < 2)});
        if (acc) begin
            last_r = r;
            last_c = c;
        end
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        IN_SOF   = 1'b0;
        IN_EOL   = 1'b0;
        @(negedge CLK);
        check("win_valid", WIN_VALID, win);
        check("taps", taps_now, exp_taps(last_r, last_c));
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge CLK);
            check("gap_win_valid", WIN_VALID, 1'b0);
            check("gap_taps_hold", taps_now, exp_taps(last_r, last_c));
        end
    endtask

    task automatic send_pixels(input int start, input int n, input bit gaps);
        for (int k = start; k < start + n; k++) begin
            pixel(k / W, k % W, (k == 0), ((k % W) == W-1), 1'b1, 1'b1);
            if (gaps && (k != start + n - 1) && ($urandom_range(1, 0) == 1))
                gap(int'($urandom_range(2, 1)));
        end
    endtask

    task automatic clear_counts();
        @(posedge CLK);
        #1;
        n_win = 0; n_out = 0; n_border = 0; n_done = 0; n_err = 0; n_abort = 0;
        first_win = -1;
        first_out = -1;
        @(negedge CLK);
    endtask

    task automatic settle();
        gap(LAT + 3);
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_dut();
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        sb.delete();
        last_r = -10;
        last_c = -10;
        n_win = 0; n_out = 0; n_border = 0; n_done = 0; n_err = 0; n_abort = 0;
        @(negedge CLK);
        check("reset_outputs", {taps_now, WIN_VALID, OUT_VALID, OUT_SOF, OUT_EOL, OUT_BORDER,
                                FRAME_DONE, ERR_LINE, FRAME_ABORT}, '0);
    endtask

    initial begin
        RESET = 1'b1;
        IN_VALID = 1'b0; IN_SOF = 1'b0; IN_EOL = 1'b0; IN_DATA = '0;
        n_win = 0; n_out = 0; n_border = 0; n_done = 0; n_err = 0; n_abort = 0;
        first_win = -1; first_out = -1;
        exp_border = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (r < 2 || c < 2) exp_border++;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("initial_reset", {taps_now, WIN_VALID, OUT_VALID, OUT_SOF, OUT_EOL, OUT_BORDER,
                                FRAME_DONE, ERR_LINE, FRAME_ABORT}, '0);
        RESET = 1'b0;

        // 1: clean back-to-back frame
        clear_counts();
        drive_cyc = cyc;
        send_pixels(0, 30, 1'b0);
        check("t1_d00_r3c5", D00, 24'h010500);
        check("t1_d11_r3c5", D11, 24'h020400);
        check("t1_d22_r3c5", D22, 24'h030300);
        send_pixels(30, 18, 1'b0);
        check("t1_frame_done", FRAME_DONE, 1'b1);
        settle();
        check("t1_win_latency", first_win - drive_cyc, 1);
        check("t1_out_latency", first_out - drive_cyc, 5);
        check("t1_out_beats", n_out, 48);
        check("t1_border_beats", n_border, exp_border);
        check("t1_done_count", n_done, 1);
        check("t1_sb_empty", sb.size(), 0);
        @(negedge CLK);

        // 2: same frame with random input gaps
        clear_counts();
        send_pixels(0, 48, 1'b1);
        check("t2_frame_done", FRAME_DONE, 1'b1);
        settle();
        check("t2_out_beats", n_out, 48);
        check("t2_border_beats", n_border, exp_border);
        check("t2_done_count", n_done, 1);
        check("t2_sb_empty", sb.size(), 0);
        @(negedge CLK);

        // 3: early EOL on row 2, ignored pixels in RESYNC, then a clean frame
        clear_counts();
        send_pixels(0, 21, 1'b0);
        pixel(2, 5, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t3_err_pulse", ERR_LINE, 1'b1);
        pixel(2, 6, 1'b0, 1'b0, 1'b0, 1'b0);
        pixel(2, 7, 1'b0, 1'b1, 1'b0, 1'b0);
        pixel(3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        gap(LAT + 3);
        send_pixels(0, 48, 1'b0);
        check("t3_frame_done", FRAME_DONE, 1'b1);
        settle();
        check("t3_err_count", n_err, 1);
        check("t3_win_count", n_win, 69);
        check("t3_out_beats", n_out, 69);
        check("t3_done_count", n_done, 1);
        @(negedge CLK);

        // 4: SOF at row 4, col 3 aborts and restarts the frame
        clear_counts();
        send_pixels(0, 35, 1'b0);
        pixel(0, 0, 1'b1, 1'b0, 1'b1, 1'b1);
        check("t4_abort_pulse", FRAME_ABORT, 1'b1);
        check("t4_first_window", {D00, D01, D02, D10, D11, D12, D21, D22}, '0);
        send_pixels(1, 47, 1'b0);
        check("t4_frame_done", FRAME_DONE, 1'b1);
        settle();
        check("t4_abort_count", n_abort, 1);
        check("t4_done_count", n_done, 1);
        check("t4_out_beats", n_out, 83);
        @(negedge CLK);

        // 5: reset mid-line on row 3
        clear_counts();
        send_pixels(0, 27, 1'b0);
        reset_dut();
        gap(LAT + 3);
        pixel(3, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        pixel(3, 4, 1'b0, 1'b1, 1'b0, 1'b0);
        pixel(0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        check("t5_no_out", n_out, 0);
        check("t5_no_win", n_win, 0);
        check("t5_no_pulses", n_done + n_err + n_abort, 0);
        @(negedge CLK);
        send_pixels(0, 48, 1'b0);
        check("t5_frame_done", FRAME_DONE, 1'b1);
        settle();
        check("t5_out_beats", n_out, 48);
        check("t5_done_count", n_done, 1);
        @(negedge CLK);

        // 6: two frames with no idle cycle between them
        clear_counts();
        send_pixels(0, 48, 1'b0);
        check("t6_done_first", FRAME_DONE, 1'b1);
        send_pixels(0, 48, 1'b0);
        check("t6_done_second", FRAME_DONE, 1'b1);
        settle();
        check("t6_done_count", n_done, 2);
        check("t6_win_count", n_win, 96);
        check("t6_out_beats", n_out, 96);
        check("t6_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
